// File: rtl/reaction_stats.sv
// Reaction-time statistics: captures NUM_ROUNDS round times and tracks best, worst and average.
// Once a game is complete, the results are cycled on the display.
module reaction_stats #(
    parameter int TIME_W     = 10,
    parameter int NUM_ROUNDS = 4,
    parameter int HOLD_TICKS = 150,
    parameter int TIME_MAX   = 999
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick,
    input  logic              time_valid,
    input  logic [TIME_W-1:0] time_in,
    input  logic              clear,
    output logic              done,
    output logic [3:0]        round_cnt,
    output logic [TIME_W-1:0] disp_val,
    output logic [2:0]        disp_sel,
    output logic              disp_blank,
    output logic [TIME_W-1:0] best,
    output logic [TIME_W-1:0] worst,
    output logic [TIME_W-1:0] avg
);
    localparam int SUM_W  = TIME_W + 3;
    localparam int LOG2N  = $clog2(NUM_ROUNDS);
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
    localparam logic [3:0]        LAST_STEP = 4'(NUM_ROUNDS + 2);
    localparam logic [TIME_W-1:0] V_MAX     = TIME_W'(TIME_MAX);

    typedef enum logic {COLLECT, CYCLE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          round_cnt_q, round_cnt_d;
    logic                done_q, done_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [TIME_W-1:0]   best_q, best_d;
    logic [TIME_W-1:0]   worst_q, worst_d;
    logic [TIME_W-1:0]   avg_q, avg_d;
    logic [TIME_W-1:0]   disp_val_q, disp_val_d;
    logic [2:0]          disp_sel_q, disp_sel_d;
    logic                disp_blank_q, disp_blank_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [3:0]          step_q, step_d;
    logic [TIME_W-1:0]   slot_q [NUM_ROUNDS];
    logic [TIME_W-1:0]   slot_d [NUM_ROUNDS];

    logic                capture;
    logic [TIME_W-1:0]   cap_v;
    logic [3:0]          adv_step;
    logic [2:0]          adv_sel;
    logic [TIME_W-1:0]   adv_val;

    assign cap_v   = (time_in > V_MAX) ? V_MAX : time_in;
    assign capture = !clear && (state_q == COLLECT) && time_valid;

    generate
        for (genvar gi = 0; gi < NUM_ROUNDS; gi++) begin : g_slot
            assign slot_d[gi] = clear ? '0 :
                                (capture && round_cnt_q == 4'(gi)) ? cap_v : slot_q[gi];
        end
    endgenerate

    // The step index is kept apart from the label because round labels can overlap 5..7.
    always_comb begin
        adv_step = (step_q == LAST_STEP) ? 4'd0 : step_q + 4'd1;
        adv_sel  = 3'd7;
        adv_val  = avg_q;
        if (adv_step < 4'(NUM_ROUNDS)) begin
            adv_sel = adv_step[2:0];
            adv_val = slot_q[adv_step[LOG2N-1:0]];
        end else if (adv_step == 4'(NUM_ROUNDS)) begin
            adv_sel = 3'd6;
            adv_val = best_q;
        end else if (adv_step == 4'(NUM_ROUNDS + 1)) begin
            adv_sel = 3'd5;
            adv_val = worst_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        round_cnt_d  = round_cnt_q;
        done_d       = done_q;
        sum_d        = sum_q;
        best_d       = best_q;
        worst_d      = worst_q;
        avg_d        = avg_q;
        disp_val_d   = disp_val_q;
        disp_sel_d   = disp_sel_q;
        disp_blank_d = disp_blank_q;
        hold_d       = hold_q;
        step_d       = step_q;
        if (clear) begin
            state_d      = COLLECT;
            round_cnt_d  = '0;
            done_d       = 1'b0;
            sum_d        = '0;
            best_d       = '1;
            worst_d      = '0;
            avg_d        = '0;
            disp_val_d   = '0;
            disp_sel_d   = '0;
            disp_blank_d = 1'b1;
            hold_d       = '0;
            step_d       = '0;
        end else if (state_q == COLLECT) begin
            if (time_valid) begin
                round_cnt_d  = round_cnt_q + 4'd1;
                sum_d        = sum_q + SUM_W'(cap_v);
                best_d       = (cap_v < best_q) ? cap_v : best_q;
                worst_d      = (cap_v > worst_q) ? cap_v : worst_q;
                disp_blank_d = 1'b0;
                disp_sel_d   = round_cnt_q[2:0];
                disp_val_d   = cap_v;
                if (round_cnt_q == 4'(NUM_ROUNDS - 1)) begin
                    done_d     = 1'b1;
                    avg_d      = TIME_W'(sum_d >> LOG2N);
                    state_d    = CYCLE;
                    step_d     = '0;
                    hold_d     = '0;
                    disp_sel_d = 3'd0;
                    disp_val_d = slot_q[0];
                end
            end
        end else if (tick) begin
            if (hold_q == HOLD_W'(HOLD_TICKS - 1)) begin
                hold_d     = '0;
                step_d     = adv_step;
                disp_sel_d = adv_sel;
                disp_val_d = adv_val;
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= COLLECT;
            round_cnt_q  <= '0;
            done_q       <= 1'b0;
            sum_q        <= '0;
            best_q       <= '1;
            worst_q      <= '0;
            avg_q        <= '0;
            disp_val_q   <= '0;
            disp_sel_q   <= '0;
            disp_blank_q <= 1'b1;
            hold_q       <= '0;
            step_q       <= '0;
            for (int i = 0; i < NUM_ROUNDS; i++) slot_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            round_cnt_q  <= round_cnt_d;
            done_q       <= done_d;
            sum_q        <= sum_d;
            best_q       <= best_d;
            worst_q      <= worst_d;
            avg_q        <= avg_d;
            disp_val_q   <= disp_val_d;
            disp_sel_q   <= disp_sel_d;
            disp_blank_q <= disp_blank_d;
            hold_q       <= hold_d;
            step_q       <= step_d;
            slot_q       <= slot_d;
        end
    end

    assign done       = done_q;
    assign round_cnt  = round_cnt_q;
    assign disp_val   = disp_val_q;
    assign disp_sel   = disp_sel_q;
    assign disp_blank = disp_blank_q;
    // The internal minimum starts at all ones, so it is hidden until something is captured.
    assign best       = (round_cnt_q == 4'd0) ? '0 : best_q;
    assign worst      = worst_q;
    assign avg        = avg_q;

endmodule

// File: tb/tb_reaction_stats.sv
// Randomised and directed bench for reaction_stats, compared every cycle with a list-based game model.
module tb_reaction_stats;
    localparam int TW   = 10;
    localparam int N    = 4;
    localparam int HOLD = 150;
    localparam int TMAX = 999;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          tick = 1'b0;
    logic          time_valid = 1'b0;
    logic [TW-1:0] time_in = '0;
    logic          clear = 1'b0;
    logic          done;
    logic [3:0]    round_cnt;
    logic [TW-1:0] disp_val;
    logic [2:0]    disp_sel;
    logic          disp_blank;
    logic [TW-1:0] best;
    logic [TW-1:0] worst;
    logic [TW-1:0] avg;

    int checks = 0;
    int failures = 0;

    // Model: captured values in order, plus position in the display sequence.
    int caps[$];
    int m_idx = 0;
    int m_hold = 0;

    always #5 clk = ~clk;

    reaction_stats #(.TIME_W(TW), .NUM_ROUNDS(N), .HOLD_TICKS(HOLD), .TIME_MAX(TMAX)) dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .time_valid(time_valid),
        .time_in(time_in), .clear(clear), .done(done), .round_cnt(round_cnt),
        .disp_val(disp_val), .disp_sel(disp_sel), .disp_blank(disp_blank),
        .best(best), .worst(worst), .avg(avg)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_min();
        int r = caps[0];
        foreach (caps[i]) if (caps[i] < r) r = caps[i];
        return r;
    endfunction

    function automatic int m_max();
        int r = 0;
        foreach (caps[i]) if (caps[i] > r) r = caps[i];
        return r;
    endfunction

    function automatic int m_avg();
        int s = 0;
        foreach (caps[i]) s += caps[i];
        return s / N;
    endfunction

    task automatic model_reset();
        caps.delete();
        m_idx = 0;
        m_hold = 0;
    endtask

    task automatic check_all();
        int n = caps.size();
        int e_sel;
        int e_val;
        check("round_cnt", int'(round_cnt), n);
        check("done", int'(done), int'(n == N));
        check("best", int'(best), (n > 0) ? m_min() : 0);
        check("worst", int'(worst), (n > 0) ? m_max() : 0);
        check("avg", int'(avg), (n == N) ? m_avg() : 0);
        check("disp_blank", int'(disp_blank), int'(n == 0));
        if (n == 0) begin
            e_sel = 0; e_val = 0;
        end else if (n < N) begin
            e_sel = n - 1; e_val = caps[n-1];
        end else if (m_idx < N) begin
            e_sel = m_idx; e_val = caps[m_idx];
        end else if (m_idx == N) begin
            e_sel = 6; e_val = m_min();
        end else if (m_idx == N + 1) begin
            e_sel = 5; e_val = m_max();
        end else begin
            e_sel = 7; e_val = m_avg();
        end
        check("disp_sel", int'(disp_sel), e_sel);
        check("disp_val", int'(disp_val), e_val);
    endtask

    // One clock cycle with the given inputs, then model update and full output check.
    task automatic cyc(input logic tv, input int tin, input logic tk, input logic clr);
        time_valid = tv;
        time_in    = TW'(tin);
        tick       = tk;
        clear      = clr;
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else if (caps.size() < N) begin
            if (tv) begin
                caps.push_back((tin > TMAX) ? TMAX : tin);
                $display("capture %0d: time_in=%0d stored=%0d", caps.size(), tin, caps[caps.size()-1]);
                if (caps.size() == N) begin
                    m_idx = 0;
                    m_hold = 0;
                end
            end
        end else if (tk) begin
            m_hold++;
            if (m_hold == HOLD) begin
                m_hold = 0;
                m_idx = (m_idx + 1) % (N + 3);
            end
        end
        #1;
        check_all();
        time_valid = 1'b0;
        tick       = 1'b0;
        clear      = 1'b0;
    endtask

    int exp_sel[8] = '{0, 1, 2, 3, 6, 5, 7, 0};
    int exp_val[8] = '{120, 340, 56, 200, 56, 340, 179, 120};
    int basic[4]   = '{120, 340, 56, 200};

    initial begin
        // Reset state, with a strobe present that must not be sampled.
        model_reset();
        #12;
        check_all();
        time_valid = 1'b1;
        time_in = TW'(77);
        @(posedge clk);
        #1;
        check("reset_ignores_strobe", int'(round_cnt), 0);
        time_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Basic capture with a strobe held high across four cycles.
        foreach (basic[i]) cyc(1'b1, basic[i], 1'b0, 1'b0);
        check("basic_done", int'(done), 1);
        check("basic_best", int'(best), 56);
        check("basic_worst", int'(worst), 340);
        check("basic_avg", int'(avg), 179);

        // Strobes during display cycling are ignored.
        cyc(1'b1, 5, 1'b0, 1'b0);
        check("ignore_best", int'(best), 56);
        check("ignore_round_cnt", int'(round_cnt), 4);

        // Display cycling with a tick every cycle.
        check("cycle_sel_0", int'(disp_sel), exp_sel[0]);
        check("cycle_val_0", int'(disp_val), exp_val[0]);
        for (int k = 1; k < 8; k++) begin
            for (int t = 0; t < HOLD; t++) cyc(1'b0, 0, 1'b1, 1'b0);
            check($sformatf("cycle_sel_%0d", k), int'(disp_sel), exp_sel[k]);
            check($sformatf("cycle_val_%0d", k), int'(disp_val), exp_val[k]);
        end

        // Clear priority over a coinciding capture.
        cyc(1'b0, 0, 1'b0, 1'b1);
        cyc(1'b1, 10, 1'b0, 1'b0);
        cyc(1'b1, 20, 1'b0, 1'b0);
        cyc(1'b1, 30, 1'b0, 1'b1);
        check("clear_round_cnt", int'(round_cnt), 0);
        check("clear_blank", int'(disp_blank), 1);
        cyc(1'b1, 40, 1'b0, 1'b0);
        check("clear_first_after", int'(disp_val), 40);

        // Saturation and zero captures.
        cyc(1'b0, 0, 1'b0, 1'b1);
        cyc(1'b1, 1023, 1'b0, 1'b0);
        cyc(1'b1, 0, 1'b0, 1'b0);
        cyc(1'b1, 0, 1'b0, 1'b0);
        cyc(1'b1, 0, 1'b0, 1'b0);
        check("sat_slot0", int'(disp_val), 999);
        check("sat_best", int'(best), 0);
        check("sat_worst", int'(worst), 999);
        check("sat_avg", int'(avg), 249);

        // Randomised traffic.
        for (int i = 0; i < 20000; i++) begin
            logic tv, tk, clr;
            int tin;
            tv  = ($urandom_range(0, 3) == 0);
            tk  = ($urandom_range(0, 1) == 1);
            clr = ($urandom_range(0, 1499) == 0);
            tin = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 1023));
            cyc(tv, tin, tk, clr);
        end

        // Asynchronous reset in the middle of display cycling.
        cyc(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < N; i++) cyc(1'b1, 100 + i, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 0, 1'b1, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_done", int'(done), 0);
        check("async_blank", int'(disp_blank), 1);
        check("async_round_cnt", int'(round_cnt), 0);
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        reset_n = 1'b1;
        cyc(1'b1, 321, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reaction_stats.md
REACTION_STATS -- requirements
Module: reaction_stats

Interface
REQ-001 SHALL have parameter TIME_W, default 10, giving the reaction-time width.
REQ-002 SHALL have parameter NUM_ROUNDS, default 4, giving rounds per game; it must be a power of two, from 2 to 8.
REQ-003 SHALL have parameter HOLD_TICKS, default 150, giving the display hold per item in tick pulses (3 s at 50 Hz).
REQ-004 SHALL have parameter TIME_MAX, default 999, giving the saturation value for captured times (3-digit BCD limit).
REQ-005 SHALL use one clock and an asynchronous, active-low reset:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have the following ports, in this order after clock and reset:
- tick  in  1  50 Hz enable, one clk cycle wide.
- time_valid  in  1  one-cycle strobe; time_in is a finished round time.
- time_in  in  TIME_W  reaction time in 10 ms units.
- clear  in  1  synchronous restart of statistics.
- done  out  1  all NUM_ROUNDS captured.
- round_cnt  out  4  number of rounds captured, 0..NUM_ROUNDS.
- disp_val  out  TIME_W  value to show on the display.
- disp_sel  out  3  item label: 0..NUM_ROUNDS-1 is round, 6 is best, 5 is worst, 7 is average.
- disp_blank  out  1  display blank request.
- best  out  TIME_W  minimum captured time.
- worst  out  TIME_W  maximum captured time.
- avg  out  TIME_W  mean of captured times.

Function
REQ-007 SHALL implement a two-state FSM, COLLECT and CYCLE; it enters COLLECT on reset or on clear.
REQ-008 In COLLECT, on each clk edge with time_valid=1, SHALL capture v = min(time_in, TIME_MAX) into slot[round_cnt].
REQ-009 On each capture, SHALL increment round_cnt, add v to sum (width TIME_W+3, no overflow possible), set best=min(best,v) and set worst=max(worst,v).
REQ-010 SHALL make all capture effects visible on the outputs on the clk cycle after the strobe (1-cycle latency, registered).
REQ-011 On the capture that makes round_cnt equal NUM_ROUNDS, SHALL register avg = sum_new >> log2(NUM_ROUNDS) (truncating), set done=1 and move to CYCLE.
REQ-012 In COLLECT, SHALL set disp_blank=1 while round_cnt=0; otherwise disp_val is the last captured v and disp_sel is the last round index.
REQ-013 In CYCLE, SHALL ignore time_valid; no slot, sum, best, worst or round_cnt change.
REQ-014 In CYCLE, SHALL set disp_blank=0 and step the display sequence round 0, 1, ..., NUM_ROUNDS-1, best(6), worst(5), avg(7), then wrap to round 0.
REQ-015 In CYCLE, SHALL advance disp_sel after HOLD_TICKS tick pulses, with the hold counter restarting from 0 at each advance and on entry to CYCLE.
REQ-016 In CYCLE, disp_val SHALL be the slot, best, worst or avg value matching disp_sel, updated on the same edge as disp_sel.
REQ-017 On entry to CYCLE, SHALL set disp_sel=0.
REQ-018 tick pulses in COLLECT SHALL have no effect.
REQ-019 When clear=1, SHALL restore all reset values on the next edge and override time_valid and tick on the same edge.
REQ-020 When clear and capture coincide, the capture SHALL be discarded.
REQ-021 A time_valid held high for k cycles in COLLECT SHALL cause k captures, up to NUM_ROUNDS; the strobe is not edge-detected.
REQ-022 time_in=0 SHALL be a legal capture and produces best=0.

Reset
REQ-023 On reset_n=0, SHALL immediately and asynchronously force the following values:
- FSM state COLLECT.
- round_cnt=0, done=0.
- disp_blank=1, disp_sel=0, disp_val=0.
- best = all ones internally; the best output shows 0 while round_cnt=0.
- worst=0, avg=0, sum=0, slots=0, hold counter=0.
REQ-024 SHALL leave reset on the first clk edge after reset_n returns high; no input is sampled during reset.
REQ-025 Reset asserted mid-CYCLE or mid-COLLECT SHALL lose all captured data.

Verification
REQ-026 Basic capture: strobe times 120, 340, 56, 200 -> best=56, worst=340, avg=179, done=1 one cycle after the 4th strobe.
REQ-027 Saturation: strobe 1023, then 0, 0, 0 -> slot0=999, best=0, worst=999, avg=249.
REQ-028 Display cycling: after REQ-026, drive 150 ticks per step -> disp_sel goes 0,1,2,3,6,5,7,0 with disp_val 120,340,56,200,56,340,179,120.
REQ-029 Ignore in CYCLE: strobe time_in=5 while done=1 -> best stays 56 and round_cnt stays 4.
REQ-030 Clear priority: assert clear and time_valid together after 2 captures -> round_cnt=0, disp_blank=1, the new value is not stored.
REQ-031 Async reset: drop reset_n mid-CYCLE between clk edges -> done=0 and disp_blank=1 without waiting for a clk edge.
